// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write / status
// outputs of the boot loader, bundled for the loader (slave) and the
// stream source / memory-side observer (master).
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_loaded;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error, words_loaded
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a byte stream (4-byte little-endian word count L, then L
// little-endian words), writes the words to consecutive word addresses
// starting at BASE_ADDR and holds the core in reset until the image is in.
// Optional feature macro: LOADER_CHECKSUM_EN -- a 4-byte checksum word
// (32-bit wrapping sum of the payload words) follows the payload; a
// mismatch aborts the load.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
    logic [31:0] r_shift, w_shift_nxt;
    logic [31:0] r_len, w_len_nxt;
    logic [31:0] r_words, w_words_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_hold, w_hold_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;

    logic        w_accept;
    logic        w_word_done;
    logic [31:0] w_word;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_sum, w_sum_nxt;
`endif

    // A byte moves only when the registered ready is high; the word being
    // completed is the incoming byte on top of the three already shifted in.
    always_comb begin
        w_accept    = bus.rx_valid & r_ready;
        w_word_done = w_accept & (r_byte_cnt == 2'd3);
        w_word      = {bus.rx_data, r_shift[31:8]};
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift_nxt    = r_shift;
        w_len_nxt      = r_len;
        w_words_nxt    = r_words;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
`ifdef LOADER_CHECKSUM_EN
        w_sum_nxt      = r_sum;
`endif

        if (w_accept) begin
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
            w_shift_nxt    = w_word;
        end else begin
            w_byte_cnt_nxt = r_byte_cnt;
        end

        case (r_state)
            HDR: begin
                if (w_word_done) begin
                    w_len_nxt = w_word;
                    if (w_word > MAX_WORDS_W) begin
                        w_state_nxt = ERR;
                    end else if (w_word == 32'd0) begin
                        w_state_nxt = END_STATE;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = HDR;
                end
            end
            DATA: begin
                if (w_word_done) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = BASE_ADDR + {r_words[29:0], 2'b00};
                    w_wdata_nxt = w_word;
                    w_words_nxt = r_words + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt   = r_sum + w_word;
`endif
                    if ((r_words + 32'd1) == r_len) begin
                        w_state_nxt = END_STATE;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_word_done) begin
                    if (w_word == r_sum) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ERR;
                    end
                end else begin
                    w_state_nxt = CSUM;
                end
`else
                // Unreachable without the checksum stage; fail safe.
                w_state_nxt = ERR;
`endif
            end
            DONE:    w_state_nxt = DONE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = ERR;
        endcase

        // Release is held off while the final write strobe is in flight so
        // the core never fetches before the last word has committed.
        w_ready_nxt = (w_state_nxt == HDR) || (w_state_nxt == DATA) ||
                      (w_state_nxt == CSUM);
        w_done_nxt  = (w_state_nxt == DONE) && !w_we_nxt;
        w_err_nxt   = (w_state_nxt == ERR);
        w_hold_nxt  = !w_done_nxt;
    end

    // State, datapath and output registers; reset returns to header capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= HDR;
            r_byte_cnt <= 2'd0;
            r_shift    <= 32'd0;
            r_len      <= 32'd0;
            r_words    <= 32'd0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
            r_ready    <= 1'b1;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_len      <= w_len_nxt;
            r_words    <= w_words_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_ready    <= w_ready_nxt;
            r_hold     <= w_hold_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running payload sum, discarded on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= 32'd0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    assign bus.rx_ready     = r_ready;
    assign bus.imem_we      = r_we;
    assign bus.imem_addr    = r_addr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.cpu_hold     = r_hold;
    assign bus.load_done    = r_done;
    assign bus.load_error   = r_err;
    assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. The stimulus side builds
// each byte stream from a word-level image description and queues the
// writes it implies; a monitor pops and compares every write strobe.
module tb_imem_loader;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MAXW      = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    imem_loader_if bus_if ();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    bit prev_we = 1'b0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] payload[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // Monitor: scoreboard for write strobes plus per-cycle invariants.
    initial begin
        logic [31:0] ea, ed;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (reset) begin
                prev_we = 1'b0;
            end else begin
                if (bus_if.imem_we) begin
                    if (exp_addr.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                                 bus_if.imem_addr, bus_if.imem_wdata);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        chk("write_addr", bus_if.imem_addr, ea);
                        chk("write_data", bus_if.imem_wdata, ed);
                    end
                    chk("we_single_cycle", 32'(prev_we), 32'd0);
                end
                prev_we = bus_if.imem_we;
                if (bus_if.load_done && done_cyc < 0) done_cyc = cyc;
                if (bus_if.load_error && err_cyc < 0) err_cyc = cyc;
                chk("hold_vs_done", 32'(bus_if.cpu_hold), 32'(!bus_if.load_done));
            end
        end
    end

    task automatic apply_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_rx_ready",  32'(bus_if.rx_ready), 32'd1);
        chk("rst_imem_we",   32'(bus_if.imem_we), 32'd0);
        chk("rst_imem_addr", bus_if.imem_addr, BASE);
        chk("rst_imem_wdata", bus_if.imem_wdata, 32'd0);
        chk("rst_cpu_hold",  32'(bus_if.cpu_hold), 32'd1);
        chk("rst_load_done", 32'(bus_if.load_done), 32'd0);
        chk("rst_load_error", 32'(bus_if.load_error), 32'd0);
        chk("rst_words",     bus_if.words_loaded, 32'd0);
        exp_addr.delete();
        exp_data.delete();
        done_cyc = -1;
        err_cyc  = -1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one byte after a random idle gap; returns the accepting cycle.
    task automatic send_byte(input logic [7:0] b, input int maxgap, output int acc);
        int gap;
        bit ok;
        gap = $urandom_range(maxgap, 0);
        acc = -1;
        ok  = 1'b0;
        if (gap > 0) begin
            bus_if.rx_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (bus_if.rx_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL byte_accept: got no acceptance expected byte 0x%02h taken", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, output int acc);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[7:0], maxgap, acc);
            v = v >> 8;
        end
    endtask

    // Reference: an image of `len` words from `payload`; derives the write
    // list, final status and the cycle at which the status must appear.
    task automatic run_load(input logic [31:0] len, input int maxgap, input logic [31:0] csum_delta);
        logic [31:0] sum;
        logic [31:0] exp_words;
        bit          exp_err;
        int          acc;
        int          exp_rise;
        sum       = 32'd0;
        exp_err   = (len > 32'(MAXW));
        exp_words = exp_err ? 32'd0 : len;
        if (!exp_err) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_addr.push_back(BASE + 32'(i) * 32'd4);
                exp_data.push_back(payload[i]);
                sum = sum + payload[i];
            end
        end
        send_word(len, maxgap, acc);
        if (!exp_err) begin
            for (int i = 0; i < int'(len); i++) send_word(payload[i], maxgap, acc);
`ifdef LOADER_CHECKSUM_EN
            send_word(sum + csum_delta, maxgap, acc);
            if (csum_delta != 32'd0) exp_err = 1'b1;
`endif
        end
        bus_if.rx_valid = 1'b0;
        exp_rise = acc;
`ifndef LOADER_CHECKSUM_EN
        if (!exp_err && len != 32'd0) exp_rise = acc + 1;
`endif
        for (int t = 0; t < 20; t++) begin
            if (bus_if.load_done || bus_if.load_error) break;
            @(posedge clk);
            #1;
        end
        if (exp_err) chk("error_cycle", 32'(err_cyc), 32'(exp_rise));
        else         chk("release_cycle", 32'(done_cyc), 32'(exp_rise));
        // Stray bytes after the end must be ignored.
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'($urandom);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus_if.rx_valid = 1'b0;
        chk("final_rx_ready",   32'(bus_if.rx_ready), 32'd0);
        chk("final_load_done",  32'(bus_if.load_done), 32'(!exp_err));
        chk("final_load_error", 32'(bus_if.load_error), 32'(exp_err));
        chk("final_cpu_hold",   32'(bus_if.cpu_hold), 32'(exp_err));
        chk("final_words",      bus_if.words_loaded, exp_words);
        chk("pending_writes",   32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        int acc;
        logic [31:0] rlen;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;

        // Two-word image, back to back, then with random gaps.
        apply_reset();
        payload = '{32'h0050_0093, 32'h00A0_0113};
        run_load(32'd2, 0, 32'd0);
        apply_reset();
        run_load(32'd2, 5, 32'd0);
        // Same image with a corrupted checksum (plain load when no checksum).
        apply_reset();
        run_load(32'd2, 0, 32'd1);

        // Oversized length and the largest accepted length.
        apply_reset();
        run_load(32'd1025, 0, 32'd0);
        apply_reset();
        run_load(32'hFFFF_FFFF, 2, 32'd0);
        apply_reset();
        payload.delete();
        for (int i = 0; i < MAXW; i++) payload.push_back($urandom);
        run_load(32'(MAXW), 0, 32'd0);

        // Empty image.
        apply_reset();
        run_load(32'd0, 0, 32'd0);

        // Reset during a write strobe drops it at once.
        apply_reset();
        exp_addr.push_back(BASE);
        exp_data.push_back(32'h1122_3344);
        send_word(32'd2, 0, acc);
        send_word(32'h1122_3344, 0, acc);
        bus_if.rx_valid = 1'b0;
        chk("we_before_reset", 32'(bus_if.imem_we), 32'd1);
        apply_reset();

        // Reset after two payload bytes, then a clean one-word reload.
        send_word(32'd1, 0, acc);
        send_byte(8'hAA, 0, acc);
        send_byte(8'h55, 0, acc);
        bus_if.rx_valid = 1'b0;
        apply_reset();
        payload = '{32'hDEAD_BEEF};
        run_load(32'd1, 1, 32'd0);

        // Randomized images.
        for (int k = 0; k < 8; k++) begin
            apply_reset();
            rlen = 32'($urandom_range(5, 0));
            payload.delete();
            for (int i = 0; i < int'(rlen); i++) payload.push_back($urandom);
            run_load(rlen, $urandom_range(3, 0), 32'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It takes a byte stream (from a UART receiver or test host) over a valid/ready handshake and assembles it into 32-bit little-endian words. It writes those words into the instruction memory's write port at consecutive word addresses and holds the core in reset until the image is fully loaded. It sits beside the core top level and drives the write side of the same instruction memory the program counter reads from.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.
- MAX_WORDS, 1024, instruction memory depth in words; largest accepted image length.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  the byte on rx_data is valid.
- rx_data  in  8  stream byte.
- rx_ready  out  1  the loader can accept a byte; a byte transfers on a clk edge where rx_valid and rx_ready are both 1.
- imem_we  out  1  one-cycle write strobe to the instruction memory.
- imem_addr  out  32  byte address of the write, word-aligned.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  core reset request; 1 while loading or in error.
- load_done  out  1  level; the image is loaded and the core is released.
- load_error  out  1  level; the load was aborted.
- words_loaded  out  32  count of words written so far.

## Operation
- Stream format: a 4-byte length L (number of words, little-endian), then L words of 4 bytes each, little-endian.
- If LOADER_CHECKSUM_EN is defined, a 4-byte checksum word follows the payload.
- States: HDR, DATA, CSUM, DONE, ERR. Reset enters HDR.
- **HDR:** collects 4 bytes into L.
  - On the edge accepting byte 4: L > MAX_WORDS goes to ERR.
  - L == 0 goes to CSUM if the macro is defined, otherwise DONE.
  - Any other L goes to DATA.
- **DATA:** a byte counter (0..3) shifts bytes into a word assembler, least significant byte first.
  - On the edge accepting byte 3, the assembled word is registered to imem_wdata.
  - imem_addr = BASE_ADDR + 4*words_loaded (32-bit, wraps modulo 2^32).
  - imem_we is 1 for exactly the following cycle; words_loaded increments on that same edge.
  - After word L: go to CSUM (macro defined) or DONE.
- **CSUM:** collects 4 bytes.
  - On the edge accepting byte 4: equal to the running sum goes to DONE, mismatch goes to ERR.
- **DONE:** terminal until reset. rx_ready=0, cpu_hold=0, load_done=1.
- **ERR:** terminal until reset. rx_ready=0, cpu_hold=1, load_error=1. No further writes.
- rx_ready=1 in HDR, DATA and CSUM.
- Bytes presented while rx_ready=0 are ignored.

## Timing
- Reset values: rx_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0. Internal counters are cleared.
- All outputs are registered.
- Write latency: imem_we is asserted the cycle after the final byte of a word is accepted.
  - At most one write per 4 accepted bytes, so no backpressure is needed; back-to-back bytes at 1 per cycle are supported.
- Release: cpu_hold falls and load_done rises together, one cycle after the final imem_we cycle. This guarantees the final write has committed before the core fetches.
  - For L=0 without the macro, the release happens the cycle after the fourth header byte is accepted.
- Gaps in rx_valid of any length stall assembly with no state change.
- Reset mid-operation:
  - Returns to HDR and drops imem_we immediately.
  - Discards any partial word and the running sum.
  - Memory already written is left untouched.

## Configuration
- LOADER_CHECKSUM_EN:
  - **Defined:** the CSUM state exists. The running sum is the 32-bit sum of all payload words, wrapping modulo 2^32. A mismatch goes to ERR.
  - **Undefined:** the CSUM state and the adder are absent. The stream ends after the payload and DATA goes directly to DONE.

## Test plan
- L=2, words 0x00500093, 0x00A00113, bytes back-to-back (macro off):
  - writes (0x0, 0x00500093) and (0x4, 0x00A00113), one cycle each;
  - one cycle after the second write: cpu_hold=0, load_done=1, words_loaded=2, rx_ready=0.
- Same image with random 0-5 cycle rx_valid gaps -> identical write sequence and final state.
- L=1025 with MAX_WORDS=1024:
  - load_error=1 on the cycle after byte 4;
  - rx_ready=0, imem_we never asserted, cpu_hold stays 1.
- L=0 (macro off) -> no writes; load_done=1 the cycle after the fourth header byte is accepted.
- Macro on, two-word image above:
  - checksum 0x00F001A6 gives load_done=1;
  - checksum 0x00F001A7 gives load_error=1 and cpu_hold=1, with both words already written.
- Reset asserted after 2 bytes of the first payload word, then a full reload with L=1, word 0xDEADBEEF:
  - imem_we drops immediately on reset;
  - the single write after reload is (BASE_ADDR, 0xDEADBEEF) and words_loaded=1.
